bram_read_capture: RTL and testbench
====================================

# bram_read_capture

Downstream stage of the BRAM read address counter. Turns its address/valid stream into BRAM read strobes, realigns returning read data for the BRAM read latency, and buffers words in a small FIFO. Presents the words on a valid/ready stream with a last-word marker. Flags overflow if the non-stallable upstream counter outruns the consumer.

## Interface
Parameters:
- AWIDTH, 8, BRAM address width; matches the counter's `cnt_o` width.
- DWIDTH, 32, BRAM data width.
- RD_LAT, 1, BRAM read latency in cycles; legal values 1 or 2.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse, same pulse that starts the read counter; loads burst_len_i.
- burst_len_i  in  AWIDTH+1  words in this burst, 0..2**AWIDTH; sampled on start_i.
- cnt_i  in  AWIDTH  read address from the counter.
- valid_i  in  1  cnt_i valid this cycle.
- bram_en_o  out  1  BRAM read enable.
- bram_addr_o  out  AWIDTH  BRAM read address.
- bram_rdata_i  in  DWIDTH  BRAM read data, RD_LAT cycles after bram_en_o.
- m_valid_o  out  1  output word available.
- m_ready_i  in  1  consumer accepts the word.
- m_data_o  out  DWIDTH  output word, the FIFO head.
- m_last_o  out  1  head word is the final word of the burst.
- busy_o  out  1  burst in progress.
- done_o  out  1  one-cycle pulse when the burst is fully consumed.
- overflow_o  out  1  sticky flag: a word was dropped.
- level_o  out  FIFO_AW+1  FIFO occupancy.

## Operation
- Address path is combinational: bram_en_o = valid_i, bram_addr_o = cnt_i.
- Alignment shift register of RD_LAT stages carries the valid bit. When the last stage is set, bram_rdata_i is a push candidate.
- Push counter (AWIDTH+1 bits) counts accepted pushes. A pushed word's last bit = (push count == len-1). The FIFO stores {last, data}.
- Push is accepted if the FIFO is not full, or a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow_o is set, and the push counter still advances. This keeps last-word marking aligned with the burst.
- Pop occurs when m_valid_o && m_ready_i. m_valid_o = (level != 0). m_data_o and m_last_o reflect the head entry combinationally from the storage registers.
- Two states, IDLE and RUN, with busy_o high in RUN:
  - IDLE→RUN on start_i with len > 0.
  - RUN→IDLE the cycle after the pop of a last-flagged word; done_o pulses in that cycle.
  - start_i with len = 0 stays in IDLE and pulses done_o the next cycle.
- If the last word is dropped by overflow, done_o pulses the cycle after the drop, with no last word delivered.
- start_i in RUN (restart): flushes the FIFO and alignment pipeline, clears overflow_o and the push counter, loads the new length, and stays in RUN. A push or pop in the same cycle is discarded.
- valid_i while IDLE: the BRAM is still strobed, but returned data is discarded and not counted.
- Reset: all outputs 0 (bram_* follow the inputs), state IDLE, FIFO empty, storage cleared, pipeline cleared. Reset overrides start_i.

## Timing
- valid_i at cycle t → BRAM strobe at t → data sampled at the end of cycle t+RD_LAT → m_valid_o high at t+RD_LAT+1. Minimum latency RD_LAT+1.
- With m_ready_i held high, throughput is 1 word/cycle, and occupancy stays ≤ 1.
- done_o goes high exactly one cycle after the last-word pop handshake; busy_o goes low in the same cycle.
- Full FIFO with simultaneous push and pop: both are accepted, level is unchanged, no overflow.
- Empty FIFO with simultaneous push and pop: the pop cannot happen (m_valid_o low); the push is accepted.
- level_o updates on the edge after a push or pop. It wraps never; its maximum is 2**FIFO_AW.

## Test plan
- RD_LAT=1, start with len=4, addresses 0..3 on 4 consecutive cycles, BRAM model data = addr+0x100, m_ready_i=1 → 0x100..0x103 out at cycles t+2..t+5; m_last_o only with 0x103; done_o one cycle after that pop; overflow_o=0.
- len=12, m_ready_i=0 until all data returned, depth 8 → level_o saturates at 8, overflow_o=1. Then drain: 8 words 0x100..0x107, none flagged last, and done_o pulsed at the 12th push cycle+1.
- Full FIFO, m_ready_i=1 on the same cycle as a push → level_o stays 8, overflow_o stays 0, data order preserved.
- start_i with len=0 → no m_valid_o; done_o pulses one cycle later; busy_o stays 0.
- Restart: start_i len=6 mid-burst with 3 words queued → FIFO empties next cycle, overflow_o cleared, the new burst delivers 6 words with last on the 6th. Repeat with RD_LAT=2, checking 3-cycle latency.
- reset asserted mid-burst with FIFO non-empty → next cycle m_valid_o=0, level_o=0, busy_o=0, done_o=0. In-flight data returning after reset is not pushed.

Source files
------------

// File: rtl/bram_read_capture.sv
// bram_read_capture: BRAM read strobe, read-latency realignment and output FIFO with last-word marking.
// Ports: clk/reset (sync, active high); start_i + burst_len_i load a burst;
//   cnt_i/valid_i from the address counter drive bram_en_o/bram_addr_o;
//   bram_rdata_i returns RD_LAT cycles later; m_valid_o/m_ready_i/m_data_o/m_last_o
//   output stream; busy_o, done_o, overflow_o (sticky) and level_o status.
module bram_read_capture #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 32,
  parameter int RD_LAT  = 1,
  parameter int FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [AWIDTH:0]   burst_len_i,
  input  logic [AWIDTH-1:0] cnt_i,
  input  logic              valid_i,
  output logic              bram_en_o,
  output logic [AWIDTH-1:0] bram_addr_o,
  input  logic [DWIDTH-1:0] bram_rdata_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [FIFO_AW:0]  level_o
);
  localparam int DEPTH = 2 ** FIFO_AW;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [AWIDTH:0] len_q, len_d, pcnt_q, pcnt_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [DWIDTH:0] mem_q [DEPTH];
  logic [DWIDTH:0] mem_d [DEPTH];
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0] lvl_q, lvl_d;
  logic ovf_q, ovf_d, done_q, done_d;
  logic cand, full, pop, push, drop, last_w, fin;
  assign bram_en_o   = valid_i;
  assign bram_addr_o = cnt_i;
  assign m_valid_o   = lvl_q != '0;
  assign m_data_o    = mem_q[rp_q][DWIDTH-1:0];
  assign m_last_o    = mem_q[rp_q][DWIDTH];
  assign busy_o      = state_q == RUN;
  assign done_o      = done_q;
  assign overflow_o  = ovf_q;
  assign level_o     = lvl_q;
  // A start (fresh or restart) discards any push/pop of its own cycle and
  // flushes older pipeline stages; the current valid_i still enters stage 0.
  always_comb begin
    cand   = pipe_q[RD_LAT-1] && state_q == RUN && !start_i;
    full   = lvl_q == (FIFO_AW+1)'(DEPTH);
    pop    = m_valid_o && m_ready_i && !start_i;
    push   = cand && (!full || pop);
    drop   = cand && !push;
    last_w = pcnt_q == len_q - (AWIDTH+1)'(1);
    pipe_d = '0;
    pipe_d[0] = valid_i;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1] && !start_i;
    mem_d = mem_q;
    if (push) mem_d[wp_q] = {last_w, bram_rdata_i};
    wp_d   = start_i ? '0 : wp_q + FIFO_AW'(push);
    rp_d   = start_i ? '0 : rp_q + FIFO_AW'(pop);
    lvl_d  = start_i ? '0 : lvl_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    // Dropped words still advance the count so the last marker stays aligned.
    pcnt_d = start_i ? '0 : pcnt_q + (AWIDTH+1)'(cand);
    len_d  = start_i ? burst_len_i : len_q;
    ovf_d  = !start_i && (ovf_q || drop);
    fin    = state_q == RUN && !start_i && ((pop && m_last_o) || (drop && last_w));
    done_d = (start_i && burst_len_i == '0) || fin;
    state_d = start_i ? (burst_len_i != '0 ? RUN : IDLE) : fin ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      pcnt_q  <= '0;
      pipe_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pcnt_q  <= pcnt_d;
      pipe_q  <= pipe_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_bram_read_capture.sv
// tb_bram_read_capture: directed checks of bram_read_capture at RD_LAT 1 and 2.
module tb_bram_read_capture;
  logic clk = 1'b0;
  logic reset, start, valid, ready;
  logic [8:0] blen;
  logic [7:0] cnt;
  logic en1, en2, mv1, mv2, last1, last2, busy1, busy2, done1, done2, ovf1, ovf2;
  logic [7:0] addr1, addr2;
  logic [31:0] d1, d2, dat1, dat2;
  logic [3:0] lvl1, lvl2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  bram_read_capture #(.RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start_i(start), .burst_len_i(blen), .cnt_i(cnt), .valid_i(valid),
    .bram_en_o(en1), .bram_addr_o(addr1), .bram_rdata_i(d1), .m_valid_o(mv1), .m_ready_i(ready),
    .m_data_o(dat1), .m_last_o(last1), .busy_o(busy1), .done_o(done1), .overflow_o(ovf1), .level_o(lvl1));
  bram_read_capture #(.RD_LAT(2)) u2 (
    .clk(clk), .reset(reset), .start_i(start), .burst_len_i(blen), .cnt_i(cnt), .valid_i(valid),
    .bram_en_o(en2), .bram_addr_o(addr2), .bram_rdata_i(d2), .m_valid_o(mv2), .m_ready_i(ready),
    .m_data_o(dat2), .m_last_o(last2), .busy_o(busy2), .done_o(done2), .overflow_o(ovf2), .level_o(lvl2));
  always @(posedge clk) begin
    if (en1) d1 <= 32'h100 + {24'd0, addr1};
    d2 <= d1;
  end
  typedef struct {
    logic st; logic [8:0] len; logic v; logic [7:0] c;
    logic mv; logic [31:0] dat; logic last; logic busy; logic done; logic [3:0] lvl;
  } vec_t;
  vec_t tv [9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic st, input logic [8:0] l, input logic v, input logic [7:0] c, input logic r);
    start = st; blen = l; valid = v; cnt = c; ready = r;
  endtask
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      drv(1'b0, 9'd0, 1'b0, 8'd0, 1'b1);
      tick();
    end
  endtask
  initial begin
    tv[0] = '{1'b1, 9'd4, 1'b0, 8'd0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd0};
    tv[1] = '{1'b0, 9'd0, 1'b1, 8'd0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 4'd0};
    tv[2] = '{1'b0, 9'd0, 1'b1, 8'd1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 4'd0};
    tv[3] = '{1'b0, 9'd0, 1'b1, 8'd2, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 4'd1};
    tv[4] = '{1'b0, 9'd0, 1'b1, 8'd3, 1'b1, 32'h101, 1'b0, 1'b1, 1'b0, 4'd1};
    tv[5] = '{1'b0, 9'd0, 1'b0, 8'd0, 1'b1, 32'h102, 1'b0, 1'b1, 1'b0, 4'd1};
    tv[6] = '{1'b0, 9'd0, 1'b0, 8'd0, 1'b1, 32'h103, 1'b1, 1'b1, 1'b0, 4'd1};
    tv[7] = '{1'b0, 9'd0, 1'b0, 8'd0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 4'd0};
    tv[8] = '{1'b0, 9'd0, 1'b0, 8'd0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'd0};
    reset = 1'b1;
    drv(1'b0, 9'd0, 1'b0, 8'd0, 1'b1);
    tick(); tick();
    reset = 1'b0;
    chk("rst_mv", mv1, 1'b0); chk("rst_lvl", lvl1, 4'd0); chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0); chk("rst_ovf", ovf1, 1'b0); chk("rst_lvl2", lvl2, 4'd0);
    // len=4 burst, ready high: table of per-cycle inputs and outputs
    for (int i = 0; i < 9; i++) begin
      drv(tv[i].st, tv[i].len, tv[i].v, tv[i].c, 1'b1);
      chk($sformatf("t1_mv[%0d]", i), mv1, tv[i].mv);
      chk($sformatf("t1_busy[%0d]", i), busy1, tv[i].busy);
      chk($sformatf("t1_done[%0d]", i), done1, tv[i].done);
      chk($sformatf("t1_lvl[%0d]", i), lvl1, tv[i].lvl);
      chk($sformatf("t1_addr[%0d]", i), {en1, addr1}, {tv[i].v, tv[i].c});
      if (tv[i].mv) begin
        chk($sformatf("t1_dat[%0d]", i), dat1, tv[i].dat);
        chk($sformatf("t1_last[%0d]", i), last1, tv[i].last);
      end
      tick();
    end
    chk("t1_ovf", ovf1, 1'b0);
    gap(4);
    // len=12 with consumer stalled: 8 kept, 4 dropped including the last
    drv(1'b1, 9'd12, 1'b0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drv(1'b0, 9'd0, 1'b1, 8'(i), 1'b0);
      if (i == 9) begin
        chk("t2_lvl_full", lvl1, 4'd8); chk("t2_ovf_pre", ovf1, 1'b0);
      end
      if (i == 10) chk("t2_ovf_set", ovf1, 1'b1);
      tick();
    end
    drv(1'b0, 9'd0, 1'b0, 8'd0, 1'b0);
    chk("t2_done_early", done1, 1'b0);
    tick();
    chk("t2_done", done1, 1'b1); chk("t2_busy", busy1, 1'b0);
    chk("t2_ovf", ovf1, 1'b1); chk("t2_lvl", lvl1, 4'd8);
    tick();
    chk("t2_done_pulse", done1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 9'd0, 1'b0, 8'd0, 1'b1);
      chk($sformatf("t2_mv[%0d]", i), mv1, 1'b1);
      chk($sformatf("t2_dat[%0d]", i), dat1, 32'h100 + i);
      chk($sformatf("t2_last[%0d]", i), last1, 1'b0);
      tick();
    end
    chk("t2_empty", mv1, 1'b0); chk("t2_done_none", done1, 1'b0);
    gap(4);
    // full FIFO with push and pop in the same cycle
    drv(1'b1, 9'd10, 1'b0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, 9'd0, 1'b1, 8'(i), i >= 9);
      tick();
    end
    drv(1'b0, 9'd0, 1'b0, 8'd0, 1'b1);
    chk("t3_lvl_a", lvl1, 4'd8); chk("t3_ovf_a", ovf1, 1'b0); chk("t3_dat_a", dat1, 32'h101);
    tick();
    chk("t3_lvl_b", lvl1, 4'd8); chk("t3_ovf_b", ovf1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_dat[%0d]", i), dat1, 32'h102 + i);
      chk($sformatf("t3_last[%0d]", i), last1, i == 7);
      tick();
    end
    chk("t3_done", done1, 1'b1); chk("t3_busy", busy1, 1'b0); chk("t3_ovf", ovf1, 1'b0);
    gap(4);
    // zero-length burst
    drv(1'b1, 9'd0, 1'b0, 8'd0, 1'b1);
    tick();
    drv(1'b0, 9'd0, 1'b0, 8'd0, 1'b1);
    chk("t4_done", done1, 1'b1); chk("t4_busy", busy1, 1'b0); chk("t4_mv", mv1, 1'b0);
    tick();
    chk("t4_done_pulse", done1, 1'b0); chk("t4_busy2", busy1, 1'b0);
    gap(4);
    // restart with FIFO full and overflow set (RD_LAT=1)
    drv(1'b1, 9'd12, 1'b0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, 9'd0, 1'b1, 8'(i), 1'b0);
      tick();
    end
    drv(1'b1, 9'd6, 1'b0, 8'd0, 1'b1);
    chk("t5_pre_ovf", ovf1, 1'b1); chk("t5_pre_lvl", lvl1, 4'd8); chk("t5_pre_busy", busy1, 1'b1);
    tick();
    chk("t5_flush_lvl", lvl1, 4'd0); chk("t5_flush_ovf", ovf1, 1'b0);
    chk("t5_flush_mv", mv1, 1'b0); chk("t5_flush_busy", busy1, 1'b1);
    for (int j = 0; j < 10; j++) begin
      drv(1'b0, 9'd0, j < 6, 8'h20 + 8'(j), 1'b1);
      chk($sformatf("t5_mv[%0d]", j), mv1, j >= 2 && j < 8);
      chk($sformatf("t5_done[%0d]", j), done1, j == 8);
      chk($sformatf("t5_busy[%0d]", j), busy1, j < 8);
      if (j >= 2 && j < 8) begin
        chk($sformatf("t5_dat[%0d]", j), dat1, 32'h120 + j - 2);
        chk($sformatf("t5_last[%0d]", j), last1, j == 7);
      end
      tick();
    end
    gap(4);
    // restart with 3 words queued, RD_LAT=2
    drv(1'b1, 9'd6, 1'b0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 9'd0, 1'b1, 8'(i), 1'b0);
      tick();
    end
    drv(1'b0, 9'd0, 1'b0, 8'd0, 1'b0);
    tick(); tick();
    drv(1'b1, 9'd6, 1'b0, 8'd0, 1'b0);
    chk("t6_pre_lvl", lvl2, 4'd3);
    tick();
    chk("t6_flush_lvl", lvl2, 4'd0); chk("t6_flush_ovf", ovf2, 1'b0);
    chk("t6_flush_mv", mv2, 1'b0); chk("t6_flush_busy", busy2, 1'b1);
    for (int j = 0; j < 11; j++) begin
      drv(1'b0, 9'd0, j < 6, 8'h30 + 8'(j), 1'b1);
      chk($sformatf("t6_mv[%0d]", j), mv2, j >= 3 && j < 9);
      chk($sformatf("t6_done[%0d]", j), done2, j == 9);
      chk($sformatf("t6_busy[%0d]", j), busy2, j < 9);
      if (j >= 3 && j < 9) begin
        chk($sformatf("t6_dat[%0d]", j), dat2, 32'h130 + j - 3);
        chk($sformatf("t6_last[%0d]", j), last2, j == 8);
      end
      tick();
    end
    gap(4);
    // reset mid-burst with data queued and in flight
    drv(1'b1, 9'd8, 1'b0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 9'd0, 1'b1, 8'(i), 1'b0);
      tick();
    end
    drv(1'b0, 9'd0, 1'b1, 8'd4, 1'b0);
    reset = 1'b1;
    chk("t7_pre_lvl", lvl1, 4'd3); chk("t7_pre_busy", busy1, 1'b1);
    tick();
    reset = 1'b0;
    drv(1'b0, 9'd0, 1'b0, 8'd0, 1'b1);
    chk("t7_mv", mv1, 1'b0); chk("t7_lvl", lvl1, 4'd0); chk("t7_busy", busy1, 1'b0);
    chk("t7_done", done1, 1'b0); chk("t7_lvl2", lvl2, 4'd0); chk("t7_busy2", busy2, 1'b0);
    tick();
    drv(1'b0, 9'd0, 1'b1, 8'd5, 1'b1);
    chk("t7_idle_en", {en1, addr1}, {1'b1, 8'd5});
    tick();
    drv(1'b0, 9'd0, 1'b0, 8'd0, 1'b1);
    tick(); tick();
    chk("t7_idle_lvl", lvl1, 4'd0); chk("t7_idle_lvl2", lvl2, 4'd0); chk("t7_idle_mv", mv1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
